lcd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 4-digit seven-segment display. Holds four 4-bit hex digits plus decimal points in a double-buffered register bank, sequences the anodes one digit at a time from a programmable prescaler, and drives the shared active-low segment bus. Sits between the switch/datapath logic that produces the values and the display pins, replacing ad-hoc divided scan clocks with a single-clock, enable-based scheduler.

---
 rtl/lcd_scan_ctrl_pkg.sv | 26 ++
 rtl/lcd_scan_ctrl_if.sv | 27 ++
 rtl/lcd_scan_ctrl_seg7_decode.sv | 30 +++
 rtl/lcd_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_lcd_scan_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/lcd_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns, FSM states, widths.
// Pure declarations; no logic, latency or backpressure of its own.
package lcd_pkg;
  localparam int IDX_W = 2;
  localparam int CNT_W = 20;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {SCAN, BLANK} state_t;
endpackage

// File: rtl/lcd_scan_ctrl_if.sv
// Write port and display pins of the scan controller, grouped as one bundle.
// master = value producer / pin observer, slave = the controller; wr_rdy gates writes and commits.
interface lcd_scan_ctrl_if;
  import lcd_pkg::*;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_data;
  logic             wr_dp;
  logic             commit;
  logic             wr_rdy;
  logic [3:0]       dig_en;
  logic [3:0]       an;
  logic [6:0]       seg;
  logic             dp;
  logic             frame_tick;

  modport master (
    output wr_en, wr_idx, wr_data, wr_dp, commit, dig_en,
    input  wr_rdy, an, seg, dp, frame_tick
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, wr_dp, commit, dig_en,
    output wr_rdy, an, seg, dp, frame_tick
  );
endinterface

// File: rtl/lcd_scan_ctrl_seg7_decode.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} pattern; purely combinational, no backpressure.
module seg7_decode
  import lcd_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/lcd_scan_ctrl.sv
// 4-digit seven-segment scanner with double-buffered digits; pins registered, 1 cycle after slot change.
// wr_rdy drops while a commit waits for the frame boundary; optional blanking via LCD_SCAN_BLANK_EN.
module lcd_scan_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 8
) (
  input  logic           clk,
  input  logic           clr,
  lcd_scan_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
`ifdef LCD_SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif

  if (SCAN_DIV < 1 || SCAN_DIV > 32'hFFFFF || BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_cfg_err
    $error("lcd_scan_ctrl: SCAN_DIV or BLANK_CYC out of range");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [3:0][3:0]  shd_dat_q, shd_dat_d, act_dat_q, act_dat_d;
  logic [3:0]       shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick_q;

  logic             scan_tc, frame_end, wr_ok, commit_ok, swap;
  logic [6:0]       dec_seg;

  assign scan_tc   = (state_q == SCAN) && (cnt_q == SCAN_LAST);
  assign frame_end = scan_tc && (idx_q == IDX_W'(3));
  assign wr_ok     = bus.wr_en && !pend_q;
  assign commit_ok = bus.commit && !pend_q;
  assign swap      = frame_end && pend_q;

  seg7_decode u_dec (
    .hex_i (act_dat_q[idx_q]),
    .seg_o (dec_seg)
  );

  // Shadow is frozen while pend is set, so the swap copies exactly what was committed.
  always_comb begin
    shd_dat_d = shd_dat_q;
    shd_dp_d  = shd_dp_q;
    act_dat_d = act_dat_q;
    act_dp_d  = act_dp_q;
    pend_d    = pend_q;
    if (wr_ok) begin
      shd_dat_d[bus.wr_idx] = bus.wr_data;
      shd_dp_d[bus.wr_idx]  = bus.wr_dp;
    end
    if (commit_ok) pend_d = 1'b1;
    if (swap) begin
      act_dat_d = shd_dat_q;
      act_dp_d  = shd_dp_q;
      pend_d    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    case (state_q)
      SCAN: begin
        if (scan_tc) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
`ifdef LCD_SCAN_BLANK_EN
          state_d = BLANK;
`endif
        end
      end
      BLANK: begin
`ifdef LCD_SCAN_BLANK_EN
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SCAN;
        end
`else
        cnt_d   = '0;
        state_d = SCAN;
`endif
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  // Disabled digits keep their slot time but leave the anode off.
  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == SCAN) begin
      seg_d = dec_seg;
      if (bus.dig_en[idx_q]) begin
        an_d = ~(4'b0001 << idx_q);
        dp_d = ~act_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      shd_dat_q <= '0;
      shd_dp_q  <= '0;
      act_dat_q <= '0;
      act_dp_q  <= '0;
      an_q      <= 4'hF;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      shd_dat_q <= shd_dat_d;
      shd_dp_q  <= shd_dp_d;
      act_dat_q <= act_dat_d;
      act_dp_q  <= act_dp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      tick_q    <= frame_end;
    end
  end

  assign bus.wr_rdy     = ~pend_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Directed bench for lcd_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2; expectations are hand-written constants.
module tb_lcd_scan_ctrl;
  localparam int SDIV = 4;
`ifdef LCD_SCAN_BLANK_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif
  localparam int SLOT  = SDIV + BLK;
  localparam int FRAME = 4 * SLOT;
  localparam logic [3:0] AN_ON [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic clk = 1'b0;
  logic clr;
  int   vecs   = 0;
  int   miscmp = 0;

  lcd_scan_ctrl_if bus ();

  lcd_scan_ctrl #(.SCAN_DIV(SDIV), .BLANK_CYC(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [1:0] i, input logic [3:0] d, input logic p, input logic c);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = i;
    bus.wr_data = d;
    bus.wr_dp   = p;
    bus.commit  = c;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.commit  = 1'b0;
  endtask

  task automatic commit_only;
    bus.commit = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
  endtask

  task automatic wait_tick;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < 100);
    chk("tick_seen", 32'(bus.frame_tick), 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a frame_tick negedge; walks the next whole frame cycle by cycle.
  task automatic frame(input logic [3:0][6:0] eseg, input logic [3:0] edp, input logic [3:0] en);
    for (int k = 1; k <= FRAME; k++) begin
      int j;
      int s;
      logic [3:0] ean;
      logic [6:0] es;
      logic       ed;
      @(negedge clk);
      j = (k - 1) % SLOT;
      s = (k - 1) / SLOT;
      if (j < BLK) begin
        ean = 4'hF;
        es  = 7'h7F;
        ed  = 1'b1;
      end else begin
        ean = en[s] ? AN_ON[s] : 4'hF;
        es  = eseg[s];
        ed  = en[s] ? ~edp[s] : 1'b1;
      end
      chk("an", 32'(bus.an), 32'(ean));
      chk("seg", 32'(bus.seg), 32'(es));
      chk("dp", 32'(bus.dp), 32'(ed));
      chk("frame_tick", 32'(bus.frame_tick), 32'(k == FRAME));
    end
  endtask

  initial begin
    clr         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_idx  = 2'd0;
    bus.wr_data = 4'h0;
    bus.wr_dp   = 1'b0;
    bus.commit  = 1'b0;
    bus.dig_en  = 4'hF;

    step(5);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    chk("rst_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);
    clr = 1'b1;

    // Write 1,2,3,4 (dp on digits 1,2); commit shares the cycle with the last write.
    wait_tick();
    wr(2'd0, 4'h1, 1'b0, 1'b0);
    wr(2'd1, 4'h2, 1'b1, 1'b0);
    wr(2'd2, 4'h3, 1'b1, 1'b0);
    wr(2'd3, 4'h4, 1'b0, 1'b1);
    chk("pend_wr_rdy", 32'(bus.wr_rdy), 32'd0);
    wait_tick();
    chk("swap_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    frame({7'h19, 7'h30, 7'h24, 7'h79}, 4'b0110, 4'hF);

    // Write while pending is dropped.
    commit_only();
    chk("pend2_wr_rdy", 32'(bus.wr_rdy), 32'd0);
    wr(2'd0, 4'h8, 1'b0, 1'b0);
    wait_tick();
    step(BLK + 1);
    chk("drop_an", 32'(bus.an), 32'hE);
    chk("drop_seg", 32'(bus.seg), 32'h79);
    wr(2'd0, 4'h8, 1'b0, 1'b1);
    wait_tick();
    step(BLK + 1);
    chk("rewr_an", 32'(bus.an), 32'hE);
    chk("rewr_seg", 32'(bus.seg), 32'h00);

    // Digit enables 0101.
    bus.dig_en = 4'b0101;
    wait_tick();
    frame({7'h19, 7'h30, 7'h24, 7'h00}, 4'b0110, 4'b0101);
    bus.dig_en = 4'hF;

    // Reset during slot 2.
    step(2 * SLOT + BLK + 1);
    chk("mid_an", 32'(bus.an), 32'hB);
    chk("mid_seg", 32'(bus.seg), 32'h30);
    clr = 1'b0;
    #1;
    chk("arst_an", 32'(bus.an), 32'hF);
    chk("arst_seg", 32'(bus.seg), 32'h7F);
    chk("arst_dp", 32'(bus.dp), 32'd1);
    chk("arst_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    chk("arst_tick", 32'(bus.frame_tick), 32'd0);
    step(2);
    clr = 1'b1;
    for (int k = 1; k <= SDIV; k++) begin
      @(negedge clk);
      chk("rel_an", 32'(bus.an), 32'hE);
      chk("rel_seg", 32'(bus.seg), 32'h40);
      chk("rel_dp", 32'(bus.dp), 32'd1);
    end
    @(negedge clk);
    chk("rel_next_an", 32'(bus.an), (BLK > 0) ? 32'hF : 32'hD);
    commit_only();
    wait_tick();
    frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
